// File: rtl/wb_mem_stage_3.sv
// wb_mem_stage_3 -- stage-3 memory access / writeback sequencer (RV32I, 3-stage).
// Runs the dmem req/ack handshake for loads and stores, stalls upstream while a
// transfer is outstanding, and drives the register-file write port.
// Optional macro WB_MISALIGN_TRAP_EN: misaligned half/word accesses are trapped
// (misaligned_out pulse, no request) instead of being force-aligned.
module wb_mem_stage_3 (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        valid_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] rs2_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] imm_in,
  input  logic [31:0] pc_plus_4_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic        mem_wr_req_in,
  input  logic        rf_wr_en_in,
  input  logic [2:0]  wb_mux_sel_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_be_out,
  input  logic        dmem_ack_in,
  input  logic [31:0] dmem_rdata_in,
  output logic        stall_out,
  output logic        rf_wr_en_out,
  output logic [4:0]  rf_rd_addr_out,
  output logic [31:0] rf_wdata_out,
  output logic        misaligned_out
);

  typedef enum logic {S_IDLE = 1'b0, S_MEM_WAIT = 1'b1} state_t;

  state_t      r_state, w_next;

  // latched memory transaction
  logic        r_we;
  logic [31:0] r_addr;      // full byte address; [1:0] kept as the lane select
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [4:0]  r_rd;
  logic        r_ld_wr;     // load will write rd (rd != 0 and write enabled)

  // writeback port registers
  logic        r_rf_we;
  logic [4:0]  r_rf_addr;
  logic [31:0] r_rf_wdata;

  logic        w_idle, w_wait;
  logic        w_is_mem, w_mis, w_start_mem, w_wb_nonmem, w_ack;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_wb_data, w_ld_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_idle      = (r_state == S_IDLE);
  assign w_wait      = (r_state == S_MEM_WAIT);
  // a store wins if both store and load-select are flagged
  assign w_is_mem    = mem_wr_req_in | (wb_mux_sel_in == 3'd1);

`ifdef WB_MISALIGN_TRAP_EN
  logic r_mis;
  assign w_mis = valid_in & w_idle & w_is_mem &
                 (((load_size_in == 2'b01) & iadder_in[0]) |
                  (load_size_in[1] & (|iadder_in[1:0])));
  assign misaligned_out = r_mis;
  // one-cycle pulse for a trapped access
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) r_mis <= 1'b0;
    else             r_mis <= w_mis;
  end
`else
  assign w_mis          = 1'b0;
  assign misaligned_out = 1'b0;
`endif

  assign w_start_mem = valid_in & w_idle & w_is_mem & ~w_mis;
  assign w_wb_nonmem = valid_in & w_idle & ~w_is_mem;
  assign w_ack       = w_wait & dmem_ack_in;

  // store lane enables and replicated data; sub-word alignment ignores low bits
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = rs2_in;
    case (load_size_in)
      2'b00: begin
        w_be    = 4'b0001 << iadder_in[1:0];
        w_wdata = {4{rs2_in[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {iadder_in[1], 1'b0};
        w_wdata = {2{rs2_in[15:0]}};
      end
      default: ;
    endcase
  end

  // load data alignment and extension from the latched lane
  assign w_byte = dmem_rdata_in[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = dmem_rdata_in[{r_addr[1], 4'b0000} +: 16];
  always_comb begin
    w_ld_data = dmem_rdata_in;
    case (r_size)
      2'b00:   w_ld_data = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'b01:   w_ld_data = {{16{~r_uns & w_half[15]}}, w_half};
      default: ;
    endcase
  end

  // writeback source select for non-memory ops; reserved codes write zero
  always_comb begin
    w_wb_data = 32'd0;
    case (wb_mux_sel_in)
      3'd0:    w_wb_data = alu_result_in;
      3'd2:    w_wb_data = imm_in;
      3'd3:    w_wb_data = iadder_in;
      3'd4:    w_wb_data = pc_plus_4_in;
      default: ;
    endcase
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_start_mem) w_next = S_MEM_WAIT;
      S_MEM_WAIT: if (dmem_ack_in) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  // latch the memory transaction when it is accepted
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_rd    <= 5'd0;
      r_ld_wr <= 1'b0;
    end else if (w_start_mem) begin
      r_we    <= mem_wr_req_in;
      r_addr  <= iadder_in;
      r_be    <= w_be;
      r_wdata <= w_wdata;
      r_size  <= load_size_in;
      r_uns   <= load_unsigned_in;
      r_rd    <= rd_addr_in;
      r_ld_wr <= rf_wr_en_in & (rd_addr_in != 5'd0);
    end
  end

  // register-file write port: single-cycle strobe, data held between writes
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_rf_we    <= 1'b0;
      r_rf_addr  <= 5'd0;
      r_rf_wdata <= 32'd0;
    end else begin
      r_rf_we <= 1'b0;
      if (w_wb_nonmem) begin
        r_rf_we    <= rf_wr_en_in & (rd_addr_in != 5'd0);
        r_rf_addr  <= rd_addr_in;
        r_rf_wdata <= w_wb_data;
      end else if (w_ack && !r_we) begin
        r_rf_we    <= r_ld_wr;
        r_rf_addr  <= r_rd;
        r_rf_wdata <= w_ld_data;
      end
    end
  end

  // request/stall come straight from state; bus fields are zero outside a transfer
  assign dmem_req_out   = w_wait;
  assign stall_out      = w_wait;
  assign dmem_we_out    = w_wait & r_we;
  assign dmem_addr_out  = w_wait ? {r_addr[31:2], 2'b00} : 32'd0;
  assign dmem_be_out    = w_wait ? r_be : 4'd0;
  assign dmem_wdata_out = w_wait ? r_wdata : 32'd0;
  assign rf_wr_en_out   = r_rf_we;
  assign rf_rd_addr_out = r_rf_addr;
  assign rf_wdata_out   = r_rf_wdata;

endmodule
